// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-tag owner and tag entry.
package dmem_arb_pkg;

  typedef enum logic {PRIO_P = 1'b0, FORCE_L = 1'b1} arb_state_e;
  typedef enum logic {OWN_P = 1'b0, OWN_L = 1'b1} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int WEA_LANE = 4;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-tag delay line: tracks which requester owns each in-flight BRAM read.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t push_i,
  output logic    p_rvalid_o,
  output logic    l_rvalid_o
);

  rd_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '{valid: 1'b0, owner: OWN_P};
    end else begin
      pipe_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Tail entry lines up with the cycle mem_dout holds that read's data.
  assign p_rvalid_o = pipe_q[DEPTH-1].valid && (pipe_q[DEPTH-1].owner == OWN_P);
  assign l_rvalid_o = pipe_q[DEPTH-1].valid && (pipe_q[DEPTH-1].owner == OWN_L);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 64-bit data BRAM (pipeline P, loader L) with loader
// starvation guard. Optional perf counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p_valid_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [63:0]       p_wdata_i,
  input  logic [1:0]        p_wflag_i,
  output logic              p_ready_o,
  output logic              p_rvalid_o,
  output logic [63:0]       p_rdata_o,
  input  logic              l_valid_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [63:0]       l_wdata_i,
  input  logic [1:0]        l_wflag_i,
  output logic              l_ready_o,
  output logic              l_rvalid_o,
  output logic [63:0]       l_rdata_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_din_o,
  output logic [7:0]        mem_wea_o,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_p_grants_o,
  output logic [31:0]       perf_l_grants_o,
  output logic [31:0]       perf_conflicts_o,
`endif
  input  logic [63:0]       mem_dout_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  arb_state_e    state_q;
  logic [CW-1:0] wait_q, wait_d;
  logic          p_gnt, l_gnt;
  logic [1:0]    wflag;
  rd_tag_t       push;

  // Grants are held low in reset so nothing reaches the BRAM.
  always_comb begin
    p_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rstn) begin
      if (state_q == FORCE_L) begin
        if (l_valid_i)      l_gnt = 1'b1;
        else if (p_valid_i) p_gnt = 1'b1;
      end else begin
        if (p_valid_i)      p_gnt = 1'b1;
        else if (l_valid_i) l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!l_valid_i || l_gnt) wait_d = '0;
    else if (wait_q != SMAX) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= PRIO_P;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        PRIO_P:  if (wait_d == SMAX)          state_q <= FORCE_L;
        FORCE_L: if (l_gnt || !l_valid_i)     state_q <= PRIO_P;
        default:                              state_q <= PRIO_P;
      endcase
    end
  end

  assign p_ready_o  = p_gnt;
  assign l_ready_o  = l_gnt;
  assign stall_o    = p_valid_i & ~p_gnt;
  assign mem_en_o   = p_gnt | l_gnt;
  assign mem_addr_o = l_gnt ? l_addr_i  : p_addr_i;
  assign mem_din_o  = l_gnt ? l_wdata_i : p_wdata_i;
  assign wflag      = l_gnt ? l_wflag_i : p_wflag_i;
  assign mem_wea_o  = mem_en_o ? {{WEA_LANE{wflag[1]}}, {WEA_LANE{wflag[0]}}} : 8'h00;

  assign push.valid = mem_en_o && (wflag == 2'b00);
  assign push.owner = l_gnt ? OWN_L : OWN_P;

  rd_tag_pipe #(.DEPTH(READ_LAT)) u_tags (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (push),
    .p_rvalid_o (p_rvalid_o),
    .l_rvalid_o (l_rvalid_o)
  );

  assign p_rdata_o = mem_dout_i;
  assign l_rdata_o = mem_dout_i;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_p_grants_o  <= '0;
      perf_l_grants_o  <= '0;
      perf_conflicts_o <= '0;
    end else begin
      if (p_gnt)                  perf_p_grants_o  <= perf_p_grants_o + 1'b1;
      if (l_gnt)                  perf_l_grants_o  <= perf_l_grants_o + 1'b1;
      if (p_valid_i && l_valid_i) perf_conflicts_o <= perf_conflicts_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-first BRAM model (READ_LAT=2, STARVE_MAX=8).
module tb_dmem_arbiter;
  localparam int READ_LAT = 2, STARVE_MAX = 8, ADDR_W = 32;

  logic clk = 1'b0, rstn = 1'b0;
  logic p_valid, l_valid, p_ready, l_ready, p_rvalid, l_rvalid, stall, mem_en;
  logic [ADDR_W-1:0] p_addr, l_addr, mem_addr;
  logic [63:0] p_wdata, l_wdata, p_rdata, l_rdata, mem_din, mem_dout;
  logic [1:0] p_wflag, l_wflag;
  logic [7:0] mem_wea;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_p, perf_l, perf_c;
`endif

  int checks = 0, failures = 0;

  dmem_arbiter #(.READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .p_valid_i(p_valid), .p_addr_i(p_addr), .p_wdata_i(p_wdata), .p_wflag_i(p_wflag),
    .p_ready_o(p_ready), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
    .l_valid_i(l_valid), .l_addr_i(l_addr), .l_wdata_i(l_wdata), .l_wflag_i(l_wflag),
    .l_ready_o(l_ready), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
    .stall_o(stall), .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_wea_o(mem_wea),
`ifdef DMEM_ARB_PERF_EN
    .perf_p_grants_o(perf_p), .perf_l_grants_o(perf_l), .perf_conflicts_o(perf_c),
`endif
    .mem_dout_i(mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first BRAM: read captures old contents, write applies afterwards.
  logic [63:0] mem [logic [ADDR_W-1:0]];
  logic [63:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin : bram
    logic [63:0] cur, nw;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en) begin
      cur = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
      rd_pipe[0] <= cur;
      nw = cur;
      for (int b = 0; b < 8; b++) if (mem_wea[b]) nw[8*b +: 8] = mem_din[8*b +: 8];
      if (|mem_wea) mem[mem_addr] = nw;
    end
  end
  assign mem_dout = rd_pipe[READ_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid = 0; l_valid = 0; p_wflag = 0; l_wflag = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    p_addr = 0; l_addr = 0; p_wdata = 0; l_wdata = 0;
    for (int i = 0; i < READ_LAT; i++) rd_pipe[i] = 64'h0;
    mem[32'h10] = 64'hDEADBEEF_01234567;
    mem[32'h20] = 64'h2020_2020_0000_0020;
    mem[32'h30] = 64'h3030_3030_0000_0030;
    mem[32'h40] = 64'h4040_4040_0000_0040;

    repeat (2) tick();
    #1;
    chk("rst_p_ready", p_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid", {p_rvalid, l_rvalid}, 0);
    chk("rst_wea", mem_wea, 0);
    rstn = 1;
    tick();

    // 1: P read, data two cycles after accept
    p_valid = 1; p_addr = 32'h10; p_wflag = 2'b00;
    #1;
    chk("t1_p_ready", p_ready, 1);
    chk("t1_l_ready", l_ready, 0);
    chk("t1_stall", stall, 0);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_wea", mem_wea, 0);
    tick(); idle(); #1;
    chk("t1_rvalid_early", p_rvalid, 0);
    tick(); #1;
    chk("t1_p_rvalid", p_rvalid, 1);
    chk("t1_p_rdata", p_rdata, 64'hDEADBEEF_01234567);
    chk("t1_l_rvalid", l_rvalid, 0);
    tick(); #1;
    chk("t1_rvalid_once", p_rvalid, 0);

    // 2: low-lane write, then read back
    p_valid = 1; p_addr = 32'h10; p_wflag = 2'b01; p_wdata = 64'hAAAA_AAAA_5555_5555;
    #1;
    chk("t2_wea", mem_wea, 8'h0F);
    chk("t2_din", mem_din, 64'hAAAA_AAAA_5555_5555);
    tick(); idle(); tick(); tick(); #1;
    chk("t2_no_rvalid", {p_rvalid, l_rvalid}, 0);
    p_valid = 1; p_wflag = 2'b00;
    tick(); idle(); tick(); #1;
    chk("t2_rd_rvalid", p_rvalid, 1);
    chk("t2_rd_data", p_rdata, 64'hDEADBEEF_55555555);
    tick();

    // 4: interleaved P, L, P reads
    p_valid = 1; p_addr = 32'h20;
    #1; chk("t4_c0_p_ready", p_ready, 1);
    tick(); p_valid = 0; l_valid = 1; l_addr = 32'h30; l_wflag = 2'b00;
    #1;
    chk("t4_c1_l_ready", l_ready, 1);
    chk("t4_c1_p_ready", p_ready, 0);
    chk("t4_c1_addr", mem_addr, 32'h30);
    tick(); l_valid = 0; p_valid = 1; p_addr = 32'h40;
    #1;
    chk("t4_c2_p_rvalid", {p_rvalid, l_rvalid}, 2'b10);
    chk("t4_c2_data", p_rdata, 64'h2020_2020_0000_0020);
    tick(); idle(); #1;
    chk("t4_c3_l_rvalid", {p_rvalid, l_rvalid}, 2'b01);
    chk("t4_c3_data", l_rdata, 64'h3030_3030_0000_0030);
    tick(); #1;
    chk("t4_c4_p_rvalid", {p_rvalid, l_rvalid}, 2'b10);
    chk("t4_c4_data", p_rdata, 64'h4040_4040_0000_0040);
    tick(); #1;
    chk("t4_c5_quiet", {p_rvalid, l_rvalid}, 2'b00);

    // 5: reset one cycle after an accepted read discards the tag
    p_valid = 1; p_addr = 32'h10;
    tick(); idle(); rstn = 0; #1;
    chk("t5_rst_outs", {p_ready, l_ready, mem_en, p_rvalid, l_rvalid, stall}, 0);
    chk("t5_rst_wea", mem_wea, 0);
    tick(); tick(); rstn = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_no_rvalid", {p_rvalid, l_rvalid}, 0);
      chk("t5_mem_en", mem_en, 0);
      tick();
    end

    // 3: both valid continuously; L once every 9 cycles
    p_valid = 1; p_addr = 32'h50; p_wflag = 2'b00;
    l_valid = 1; l_addr = 32'h60; l_wflag = 2'b00;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk($sformatf("t3_l_ready_%0d", i), l_ready, (i % 9 == 8));
      chk($sformatf("t3_p_ready_%0d", i), p_ready, (i % 9 != 8));
      chk($sformatf("t3_stall_%0d", i), stall, (i % 9 == 8));
      tick();
    end
    idle(); #1;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_p", perf_p, 16);
    chk("perf_l", perf_l, 2);
    chk("perf_c", perf_c, 18);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single 64-bit data-memory port between two requesters: the pipeline memory stage (P) and the boot/program loader (L).
- Each requester uses a valid/ready handshake.
- Read data returns after a fixed BRAM latency, tagged back to the issuing requester.
- The block generates the pipeline stall and guarantees the loader forward progress via a starvation counter.
- It sits between memory1 and the data BRAM.

Parameters:
READ_LAT, 2, BRAM read latency in cycles (1..4)
STARVE_MAX, 8, max consecutive cycles L may wait while P holds the port
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
p_valid  in  1  pipeline request valid
p_addr  in  ADDR_W  pipeline address
p_wdata  in  64  pipeline write data
p_wflag  in  2  bit0 writes lane [31:0], bit1 writes lane [63:32]; 00 = read
p_ready  out  1  pipeline request accepted this cycle
p_rvalid  out  1  pipeline read data valid
p_rdata  out  64  pipeline read data
l_valid  in  1  loader request valid
l_addr  in  ADDR_W  loader address
l_wdata  in  64  loader write data
l_wflag  in  2  as p_wflag
l_ready  out  1  loader request accepted
l_rvalid  out  1  loader read data valid
l_rdata  out  64  loader read data
stall  out  1  p_valid & ~p_ready, to pipeline interlock
mem_en  out  1  BRAM enable
mem_addr  out  ADDR_W  BRAM address
mem_din  out  64  BRAM write data
mem_wea  out  8  byte write enables
mem_dout  in  64  BRAM read data

Behaviour:
Clock and reset:
- Clock clk; reset rstn, synchronous, active-low.
- On reset: FSM=PRIO_P, wait_cnt=0, all tag-pipe entries invalid.
- All registered outputs are 0 during and after reset until the next request.

Grant (combinational from current state):
- State PRIO_P: grant P if p_valid; else grant L if l_valid.
- State FORCE_L: grant L if l_valid; else grant P if p_valid.
- p_ready / l_ready = grant to that requester. At most one is high per cycle.

Memory port drive:
- mem_en = any grant.
- mem_addr, mem_din are muxed from the granted requester.
- mem_wea[3:0] = {4{wflag[0]}} and mem_wea[7:4] = {4{wflag[1]}} when granted, else 0.

Starvation counter and FSM:
- wait_cnt increments each cycle with l_valid & ~l_ready, saturating at STARVE_MAX.
- wait_cnt clears on an L grant or when l_valid=0.
- PRIO_P -> FORCE_L when the next wait_cnt value equals STARVE_MAX.
- FORCE_L -> PRIO_P after exactly one L grant, or immediately if l_valid drops.

Read response path:
- A granted read (wflag==00) pushes {1, owner} into a READ_LAT-deep tag shift register. Writes and idle cycles push {0, x}.
- At the tag tail: the owner's rvalid=1 for exactly one cycle. p_rdata and l_rdata both carry mem_dout; only rvalid qualifies the data.
- Read latency: request-accept cycle + READ_LAT.
- Back-to-back reads: one per cycle, in order.

Boundary conditions:
- Simultaneous valid in PRIO_P: P wins. In FORCE_L: L wins.
- A write to the same address as an in-flight read returns the old data, per BRAM read-first mode.
- Reset mid-operation: all in-flight tags are discarded. No rvalid is issued for a read accepted before reset.
- Requesters must hold addr/data/wflag stable while valid & ~ready.

Optional Feature:
Macro: DMEM_ARB_PERF_EN
- Defined: adds three 32-bit wrapping counters, each reset to 0 and exposed as outputs perf_p_grants, perf_l_grants, perf_conflicts.
  - perf_p_grants counts P grants.
  - perf_l_grants counts L grants.
  - perf_conflicts counts cycles with p_valid & l_valid.
- Not defined: those ports and the logic are absent. Functional behaviour is identical.

Decomposition:
Package dmem_arb_pkg holds:
- typedef arb_state_e {PRIO_P, FORCE_L}
- typedef owner_e {OWN_P, OWN_L}
- struct rd_tag_t {logic valid; owner_e owner;}
- localparam WEA_LANE=4

Sub-module rd_tag_pipe (parameter DEPTH=READ_LAT) implements the tag shift register and rvalid decode. It is instantiated once.

Test Plan:
1. P read addr 0x10 (mem holds 0xDEADBEEF_01234567), L idle -> p_ready same cycle; p_rvalid exactly READ_LAT=2 cycles later with that data; l_rvalid stays 0.
2. P write wflag=01 data 0xAAAA_AAAA_5555_5555 -> mem_wea=0x0F, no rvalid; a subsequent read returns only the low lane updated.
3. p_valid and l_valid both held high continuously -> L granted exactly once in every 9 cycles (8 P grants then 1 L grant, STARVE_MAX=8); stall=1 on each L-grant cycle.
4. Interleaved reads P,L,P on consecutive cycles -> rvalids return in the same order on the correct ports at cycles +2,+3,+4.
5. Assert rstn=0 one cycle after a P read is accepted -> no p_rvalid ever appears; all outputs 0; state=PRIO_P.
6. With DMEM_ARB_PERF_EN defined, run scenario 3 for 18 cycles -> perf_p_grants=16, perf_l_grants=2, perf_conflicts=18.
